twos_to_signmag: RTL and testbench



---
 rtl/mini_alu_pkg.sv | 13 +
 rtl/tc_serial_cell.sv | 27 ++
 rtl/twos_to_signmag.sv | 98 +++++++++
 tb/tb_twos_to_signmag.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_alu_pkg.sv
// Shared definitions for the Mini_ALU serial datapath blocks.
// The state encoding is common to every bit-serial unit on the result path.
package mini_alu_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_e;

endpackage

// File: rtl/tc_serial_cell.sv
// One-bit two's-complement negation cell: passes bits through until the first 1
// has gone by, then inverts the remaining bits when the operand is negative.
module tc_serial_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    input  logic sign,
    output logic bit_out
);

    logic seen_one_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_one_reg <= 1'b0;
        end else if (clear) begin
            seen_one_reg <= 1'b0;
        end else if (enable) begin
            seen_one_reg <= seen_one_reg | bit_in;
        end
    end

    assign bit_out = (sign & seen_one_reg) ? ~bit_in : bit_in;

endmodule

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude decoder, one bit per clock,
// LSB first, with valid/ready handshakes on both sides.
module twos_to_signmag
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_min
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    serial_state_e    state_reg, state_next;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             sign_reg;
    logic             min_reg;
    logic             cell_out;
    logic             accept;
    logic             last_bit;

    assign accept      = in_valid & (state_reg == IDLE);
    assign last_bit    = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
    assign result_next = {cell_out, result_reg[WIDTH-1:1]};
    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);

    tc_serial_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg == IDLE),
        .enable  (state_reg == SHIFT),
        .bit_in  (operand_reg[0]),
        .sign    (sign_reg),
        .bit_out (cell_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_reg <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            sign_reg    <= 1'b0;
            min_reg     <= 1'b0;
            out_sign    <= 1'b0;
            out_mag     <= '0;
            out_min     <= 1'b0;
        end else if (accept) begin
            operand_reg <= in_data;
            result_reg  <= '0;
            cnt_reg     <= '0;
            sign_reg    <= in_data[WIDTH-1];
            min_reg     <= (in_data == MIN_VAL);
        end else if (state_reg == SHIFT) begin
            operand_reg <= operand_reg >> 1;
            result_reg  <= result_next;
            cnt_reg     <= cnt_reg + 1'b1;
            // Result outputs only move on the final bit, so they never glitch mid-conversion.
            if (last_bit) begin
                out_sign <= sign_reg;
                out_mag  <= result_next;
                out_min  <= min_reg;
            end
        end
    end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Directed bench for twos_to_signmag: known vectors, back-pressure,
// reset during conversion and a full 64-value back-to-back sweep.
module tb_twos_to_signmag;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_min;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    twos_to_signmag #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_min   (out_min)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive an operand; returns at the negedge just after the accepting edge.
    task automatic send(input logic [W-1:0] d, output int acc);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_out(output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({out_valid, out_sign, out_mag, out_min} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b sign=%0b mag=%b min=%0b required all 0",
                     out_valid, out_sign, out_mag, out_min);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        $display("[TB] reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    endtask

    task automatic test_convert(input logic [W-1:0] d, input logic exp_sign,
                                input logic [W-1:0] exp_mag, input logic exp_min);
        int acc, lat;
        send(d, acc);
        wait_out(lat);
        tests++;
        if (lat !== W) begin
            fails++;
            $display("FAIL latency in=%b: got %0d required %0d", d, lat, W);
        end
        tests++;
        if (out_sign !== exp_sign || out_mag !== exp_mag || out_min !== exp_min) begin
            fails++;
            $display("FAIL convert in=%b: sign=%0b mag=%b min=%0b required sign=%0b mag=%b min=%0b",
                     d, out_sign, out_mag, out_min, exp_sign, exp_mag, exp_min);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL pop in=%b: out_valid=%0b in_ready=%0b required 0/1", d, out_valid, in_ready);
        end
        $display("[TB] convert in=%b -> sign=%0b mag=%b min=%0b latency=%0d",
                 d, out_sign, out_mag, out_min, lat);
    endtask

    task automatic test_basic();
        test_convert(6'b001101, 1'b0, 6'b001101, 1'b0);
        test_convert(6'b110011, 1'b1, 6'b001101, 1'b0);
        test_convert(6'b100000, 1'b1, 6'b100000, 1'b1);
        test_convert(6'b111111, 1'b1, 6'b000001, 1'b0);
        test_convert(6'b000000, 1'b0, 6'b000000, 1'b0);
        test_convert(6'b011111, 1'b0, 6'b011111, 1'b0);
    endtask

    task automatic test_back_pressure();
        int acc, lat;
        send(6'b110011, acc);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 6'b111000;
            end
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== 1'b1 ||
                out_mag !== 6'b001101 || out_min !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle %0d: valid=%0b ready=%0b sign=%0b mag=%b min=%0b required 1/0/1/001101/0",
                         i, out_valid, in_ready, out_sign, out_mag, out_min);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_data   = 6'b000111;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_accept: in_ready=%0b required 0", in_ready);
        end
        wait_out(lat);
        tests++;
        if (lat !== W || out_sign !== 1'b0 || out_mag !== 6'b000111 || out_min !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_result: lat=%0d sign=%0b mag=%b min=%0b required %0d/0/000111/0",
                     lat, out_sign, out_mag, out_min, W);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("[TB] back_pressure: next result mag=%b latency=%0d", out_mag, lat);
    endtask

    task automatic test_reset_mid_shift();
        int acc;
        int seen = 0;
        send(6'b110011, acc);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_sign, out_mag, out_min} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: valid=%0b sign=%0b mag=%b min=%0b ready=%0b required 0/0/0/0/1",
                     out_valid, out_sign, out_mag, out_min, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0 || out_mag !== '0) begin
            fails++;
            $display("FAIL mid_reset_discard: out_valid high %0d cycles mag=%b required 0/000000", seen, out_mag);
        end
        $display("[TB] reset mid-shift: discarded, valid cycles=%0d", seen);
        test_convert(6'b000101, 1'b0, 6'b000101, 1'b0);
    endtask

    task automatic test_back_to_back();
        int acc, prev_acc, n;
        logic [W-1:0] v, neg;
        prev_acc  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            v = W'((i * 37 + 11) % 64);
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            in_valid = 1'b1;
            in_data  = v;
            @(negedge clk);
            acc = cyc;
            if (i > 0) begin
                tests++;
                if (acc - prev_acc != W + 2) begin
                    fails++;
                    $display("FAIL interval in=%b: got %0d required %0d", v, acc - prev_acc, W + 2);
                end
            end
            prev_acc = acc;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            neg = -out_mag;
            tests++;
            if (out_valid !== 1'b1 || out_sign !== v[W-1] || out_min !== (v == 6'b100000) ||
                (out_sign ? (neg !== v) : (out_mag !== v))) begin
                fails++;
                $display("FAIL sweep in=%b: valid=%0b sign=%0b mag=%b min=%0b required sign=%0b min=%0b",
                         v, out_valid, out_sign, out_mag, out_min, v[W-1], (v == 6'b100000));
            end
            $display("[TB] sweep in=%b -> sign=%0b mag=%b min=%0b", v, out_sign, out_mag, out_min);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
